// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and byte width.
// The transmit side imports this package as well.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead byte FIFO: rdata presents the head entry whenever empty is low.
// A push and a pop in the same cycle both take effect, even when the FIFO is full.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              overflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_next;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  one_left;
  logic                  do_pop;
  logic                  do_push;

  assign empty    = (count == '0);
  assign full     = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign one_left = (count == (DEPTH_LOG2 + 1)'(1));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rd_next  = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // The head is kept in its own register so it can reset to zero and hold its
  // last value once the FIFO drains, instead of exposing a stale memory slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rdata    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_next;
      end

      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (push && !do_push) begin
        overflow <= 1'b1;
      end

      if (do_pop) begin
        if (!one_left) begin
          rdata <= mem[rd_next];
        end else if (do_push) begin
          rdata <= wdata;
        end
      end else if (empty && do_push) begin
        rdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchronizes rxd, recovers bytes by mid-bit sampling and
// queues good bytes in a show-ahead FIFO for the core to pop.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  input  logic              uart_rdreq,
  output logic              uart_empty,
  output logic [DATA_W-1:0] uart_in,
  output logic              overflow,
  output logic              frame_err
);

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic [1:0]        sync;
  logic              rxd_s;
  rx_state_t         state;
  rx_state_t         state_n;
  logic [15:0]       cnt;
  logic [15:0]       cnt_n;
  logic [2:0]        idx;
  logic [2:0]        idx_n;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_n;
  logic              frame_err_n;
  logic              push;

  // Synchronizer resets high so a reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rxd};
    end
  end

  assign rxd_s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      frame_err <= frame_err_n;
    end
  end

  // The start bit is re-checked at its midpoint; from there each full bit
  // period lands the sample in the middle of the next bit.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 16'd1;
    idx_n       = idx;
    shreg_n     = shreg;
    frame_err_n = 1'b0;
    push        = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rxd_s) begin
          state_n = START;
        end
      end

      START: begin
        if (cnt == HALF_BIT) begin
          cnt_n   = '0;
          state_n = rxd_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_n          = '0;
          shreg_n[idx]   = rxd_s;
          idx_n          = idx + 3'd1;
          if (idx == 3'd7) begin
            state_n = STOP;
          end
        end
      end

      STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_n = '0;
          if (rxd_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        cnt_n = '0;
        if (rxd_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  uart_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wdata   (shreg),
    .pop     (uart_rdreq),
    .rdata   (uart_in),
    .empty   (uart_empty),
    .overflow(overflow)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames are driven bit by bit,
// accepted bytes go into a scoreboard queue and are compared as they are popped.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       uart_rdreq;
  logic       uart_empty;
  logic [7:0] uart_in;
  logic       overflow;
  logic       frame_err;

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         fe_count     = 0;
  int         model_count  = 0;
  bit         model_ovf    = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
  } vec_t;

  vec_t vecs[5];

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH_LOG2  (DL2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .uart_rdreq(uart_rdreq),
    .uart_empty(uart_empty),
    .uart_in   (uart_in),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_count++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one full 8N1 frame; with pop_at_push the core pops on the exact
  // cycle the receiver pushes (156 clocks after the start bit is driven).
  task automatic applyStimulus(input logic [7:0] data, input bit stop_ok,
                               input bit pop_at_push);
    logic [9:0] frame;
    int         fe_before;
    logic [7:0] head;
    frame     = {stop_ok, data, 1'b0};
    fe_before = fe_count;
    for (int n = 0; n < 10 * CPB; n++) begin
      @(negedge clk);
      rxd = frame[n / CPB];
      if (pop_at_push && n == 155) begin
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard has head for same-cycle pop", 0, 1);
        end else begin
          head = exp_q.pop_front();
          checkOutput("head before same-cycle push/pop", uart_in, head);
          model_count--;
        end
        uart_rdreq = 1'b1;
      end
      if (pop_at_push && n == 156) uart_rdreq = 1'b0;
    end
    @(negedge clk);
    rxd = 1'b1;
    if (stop_ok) begin
      if (model_count < DEPTH) begin
        exp_q.push_back(data);
        model_count++;
      end else begin
        model_ovf = 1'b1;
      end
    end
    idleCycles(6);
    checkOutput("frame_err pulse count", fe_count - fe_before, stop_ok ? 0 : 1);
    checkOutput("uart_empty after frame", uart_empty, model_count == 0);
    checkOutput("overflow after frame", overflow, model_ovf);
  endtask

  task automatic popByte();
    logic [7:0] head;
    checkOutput("uart_empty before pop", uart_empty, 1'b0);
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard has head for pop", 0, 1);
    end else begin
      head = exp_q.pop_front();
      checkOutput("uart_in head byte", uart_in, head);
      model_count--;
    end
    uart_rdreq = 1'b1;
    @(negedge clk);
    uart_rdreq = 1'b0;
  endtask

  initial begin
    int  fe_before;
    bit  empty_fell;

    vecs[0] = '{data: 8'hA5, stop_ok: 1'b1};
    vecs[1] = '{data: 8'h3C, stop_ok: 1'b0};
    vecs[2] = '{data: 8'h01, stop_ok: 1'b1};
    vecs[3] = '{data: 8'hC3, stop_ok: 1'b1};
    vecs[4] = '{data: 8'h80, stop_ok: 1'b1};

    rst_n      = 1'b0;
    rxd        = 1'b1;
    uart_rdreq = 1'b0;
    idleCycles(3);
    checkOutput("reset uart_empty", uart_empty, 1'b1);
    checkOutput("reset uart_in", uart_in, 8'h00);
    checkOutput("reset overflow", overflow, 1'b0);
    checkOutput("reset frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    idleCycles(3);

    uart_rdreq = 1'b1;
    idleCycles(3);
    uart_rdreq = 1'b0;
    checkOutput("rdreq while empty ignored", uart_empty, 1'b1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].data, vecs[i].stop_ok, 1'b0);
      if (vecs[i].stop_ok) begin
        popByte();
        checkOutput("uart_empty after single pop", uart_empty, 1'b1);
      end
    end

    fe_before  = fe_count;
    empty_fell = 1'b0;
    rxd        = 1'b0;
    idleCycles(4);
    rxd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (uart_empty !== 1'b1) empty_fell = 1'b1;
    end
    checkOutput("glitch keeps FIFO empty", empty_fell, 1'b0);
    checkOutput("glitch frame_err pulses", fe_count - fe_before, 0);
    applyStimulus(8'h42, 1'b1, 1'b0);
    popByte();

    for (int i = 0; i <= 16; i++) applyStimulus(8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) popByte();
    checkOutput("empty after draining overflowed FIFO", uart_empty, 1'b1);
    checkOutput("overflow sticky after drain", overflow, 1'b1);

    applyStimulus(8'h99, 1'b1, 1'b0);
    rxd = 1'b0;
    idleCycles(CPB);
    rxd = 1'b1;
    idleCycles(4 * CPB + CPB / 2);
    rst_n = 1'b0;
    idleCycles(2);
    checkOutput("mid-frame reset uart_empty", uart_empty, 1'b1);
    checkOutput("mid-frame reset uart_in", uart_in, 8'h00);
    checkOutput("mid-frame reset overflow", overflow, 1'b0);
    checkOutput("mid-frame reset frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    exp_q.delete();
    model_count = 0;
    model_ovf   = 1'b0;
    idleCycles(4 * CPB);
    checkOutput("no byte after aborted frame", uart_empty, 1'b1);
    applyStimulus(8'h5A, 1'b1, 1'b0);
    popByte();

    for (int i = 0; i < 16; i++) applyStimulus(8'h80 + 8'(i), 1'b1, 1'b0);
    applyStimulus(8'h77, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) popByte();
    checkOutput("empty after full push/pop drain", uart_empty, 1'b1);

    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b1);
    popByte();
    checkOutput("empty after one-entry push/pop", uart_empty, 1'b1);
    checkOutput("frame_err idle at end", frame_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 4..65535.
REQ-002 Parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rxd  input  1  serial line, 8N1, idle high, asynchronous to clk.
REQ-006 uart_rdreq  input  1  core pop request, one byte per asserted cycle.
REQ-007 uart_empty  output  1  high when FIFO holds no bytes.
REQ-008 uart_in  output  8  head-of-FIFO byte (show-ahead), valid while uart_empty low.
REQ-009 overflow  output  1  sticky; byte lost because FIFO full.
REQ-010 frame_err  output  1  one-cycle pulse; stop bit sampled low.

Function
REQ-011 rxd passes through a 2-flop synchronizer before any use; all line timing below refers to the synchronized signal.
REQ-012 Receiver FSM states IDLE, START, DATA, STOP, WAIT_IDLE; a bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) drive it.
REQ-013 IDLE: synchronized rxd low -> START, bit counter cleared.
REQ-014 START: at count CLKS_PER_BIT/2 (integer divide), rxd low -> DATA with counter cleared; rxd high -> IDLE (glitch rejected, nothing stored).
REQ-015 DATA: each time counter reaches CLKS_PER_BIT-1, sample rxd into bit[index], LSB first; after index 7 -> STOP.
REQ-016 STOP: at counter CLKS_PER_BIT-1, rxd high -> push byte, -> IDLE; rxd low -> frame_err pulse, byte discarded, -> WAIT_IDLE.
REQ-017 WAIT_IDLE: stay until synchronized rxd high, then -> IDLE.
REQ-018 Push when FIFO full and uart_rdreq low: byte dropped, overflow set; FIFO contents unchanged.
REQ-019 Push and pop in same cycle: both take effect, count unchanged; applies when full (push accepted) and when one entry present.
REQ-020 uart_rdreq while uart_empty high: ignored, no pointer or count change.
REQ-021 Pointers wrap modulo 2**DEPTH_LOG2; count is DEPTH_LOG2+1 bits, range 0..2**DEPTH_LOG2.
REQ-022 Latency: pushed byte visible on uart_in with uart_empty low on the cycle after the push edge.
REQ-023 After pop, uart_in shows the next entry the following cycle; uart_in value while empty is don't-care but holds last head value.
REQ-024 overflow clears only on reset.

Reset
REQ-025 rst_n low: FSM -> IDLE, counters 0, synchronizer flops 1, FIFO pointers and count 0, uart_empty 1, uart_in 8'h00, overflow 0, frame_err 0.
REQ-026 Reset asserted mid-frame abandons the partial byte; after release, reception restarts only on a fresh falling edge.

Structure
REQ-027 Shared package uart_pkg holds the FSM state enum, default CLKS_PER_BIT, and data width 8 constant (shared with the transmit side).
REQ-028 FIFO storage and pointer logic in one sub-module uart_fifo (show-ahead, parameter DEPTH_LOG2); FSM and sampling in uart_rx_fifo.

Verification
REQ-029 Bench uses CLKS_PER_BIT=16, DEPTH_LOG2=4.
REQ-030 Single frame 8'hA5, valid stop -> uart_empty falls, uart_in=8'hA5; one uart_rdreq -> uart_empty high next cycle.
REQ-031 Low glitch of 4 cycles on idle rxd -> FSM returns IDLE, uart_empty stays 1, frame_err never pulses.
REQ-032 Frame 8'h3C with stop bit low -> one frame_err pulse, FIFO empty; next valid frame 8'h01 (after line high) received correctly.
REQ-033 17 frames 8'h00..8'h10 with no reads -> overflow=1, 16 pops return 8'h00..8'h0F in order, byte 8'h10 absent.
REQ-034 FIFO full, uart_rdreq asserted on push cycle of 8'h77 -> overflow stays 0, count stays 16, 8'h77 last out.
REQ-035 rst_n pulsed low during DATA bit 4 of 8'hFF -> all outputs at reset values, no byte stored; following frame 8'h5A received.
